// File: rtl/npc_trap_pkg.sv
// Shared definitions for the trap sequencer of the RV32 NPC core.
//   - trap_state_e : sequencer states IDLE -> TRAP|MRET -> REDIR -> IDLE
//   - cause codes for timer interrupt, illegal instruction and ecall
//   - machine CSR addresses and mstatus bit positions
package npc_trap_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAP  = 2'd1,
        MRET  = 2'd2,
        REDIR = 2'd3
    } trap_state_e;

    // Exception codes; the interrupt bit (MSB) is added by the encoder.
    localparam int unsigned CAUSE_TIMER_CODE = 7;
    localparam int unsigned CAUSE_ILLEGAL    = 2;
    localparam int unsigned CAUSE_ECALL      = 11;

    localparam logic [11:0] CSR_MSTATUS = 12'h300;
    localparam logic [11:0] CSR_MTVEC   = 12'h305;
    localparam logic [11:0] CSR_MEPC    = 12'h341;
    localparam logic [11:0] CSR_MCAUSE  = 12'h342;

    localparam int unsigned MSTATUS_MIE    = 3;
    localparam int unsigned MSTATUS_MPIE   = 7;
    localparam int unsigned MSTATUS_MPP_LO = 11;
    localparam int unsigned MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/trap_cause_enc.sv
// Combinational priority encoder for trap events.
// Priority: irq > illegal > ecall > mret. Only the winning event is reported.
// Ports:
//   irq      in   qualified interrupt (already gated by mstatus.MIE)
//   illegal  in   illegal-opcode flag
//   ecall    in   ecall flag
//   mret     in   mret flag
//   take     out  some event is pending
//   is_mret  out  winning event is mret (no trap, restore path)
//   cause    out  mcause value for trap events (0 for mret/none)
module trap_cause_enc
    import npc_trap_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            irq,
    input  logic            illegal,
    input  logic            ecall,
    input  logic            mret,
    output logic            take,
    output logic            is_mret,
    output logic [XLEN-1:0] cause
);

    always_comb begin
        take    = 1'b0;
        is_mret = 1'b0;
        cause   = '0;
        if (irq) begin
            take  = 1'b1;
            cause = {1'b1, (XLEN-1)'(CAUSE_TIMER_CODE)};
        end else if (illegal) begin
            take  = 1'b1;
            cause = XLEN'(CAUSE_ILLEGAL);
        end else if (ecall) begin
            take  = 1'b1;
            cause = XLEN'(CAUSE_ECALL);
        end else if (mret) begin
            take    = 1'b1;
            is_mret = 1'b1;
        end
    end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer between EXU and IFU.
// Accepts ecall/mret/illegal/timer events from EXU while idle, pulses the CSR
// trap update (or the mret mstatus restore), stalls the core, then hands IFU a
// redirect PC (mtvec for traps, mepc for mret) over a valid/ready handshake.
// Optional feature: define TRAP_TIMER_IRQ_EN to route timer_irq through an
// IRQ_SYNC-deep synchroniser and make it eligible when mstatus.MIE=1.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   ex_valid/ex_pc            EXU instruction valid and its PC
//   ex_ecall/ex_mret/ex_illegal  instruction event flags
//   timer_irq                 async level timer interrupt
//   csr_mtvec/mepc/mstatus    current CSR values
//   trap_req/cause/epc        one-cycle trap update to CSR file
//   csr_wen/waddr/wdata       one-cycle mstatus write for mret
//   core_stall                freezes EXU/WBU during the sequence
//   redir_valid/pc/ready      redirect handshake to IFU
module trap_ctrl
    import npc_trap_pkg::*;
#(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned IRQ_SYNC = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_ecall,
    input  logic            ex_mret,
    input  logic            ex_illegal,
    input  logic            timer_irq,
    input  logic [XLEN-1:0] csr_mtvec,
    input  logic [XLEN-1:0] csr_mepc,
    input  logic [XLEN-1:0] csr_mstatus,
    output logic            trap_req,
    output logic [XLEN-1:0] trap_cause,
    output logic [XLEN-1:0] trap_epc,
    output logic            csr_wen,
    output logic [XLEN-1:0] csr_waddr,
    output logic [XLEN-1:0] csr_wdata,
    output logic            core_stall,
    output logic            redir_valid,
    output logic [XLEN-1:0] redir_pc,
    input  logic            redir_ready
);

    trap_state_e     state_q;
    logic            irq_pend;
    logic            irq_take;
    logic            ev_take;
    logic            ev_is_mret;
    logic [XLEN-1:0] ev_cause;

    // mstatus after mret: MIE <= MPIE, MPIE <= 1, MPP <= M-mode.
    function automatic logic [XLEN-1:0] mret_mstatus(input logic [XLEN-1:0] ms);
        logic [XLEN-1:0] r;
        r                                = ms;
        r[MSTATUS_MIE]                   = ms[MSTATUS_MPIE];
        r[MSTATUS_MPIE]                  = 1'b1;
        r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
        return r;
    endfunction

`ifdef TRAP_TIMER_IRQ_EN
    logic [IRQ_SYNC-1:0] irq_sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_sync_q <= '0;
        end else begin
            irq_sync_q <= {irq_sync_q[IRQ_SYNC-2:0], timer_irq};
        end
    end

    assign irq_pend = irq_sync_q[IRQ_SYNC-1];
`else
    logic unused_irq;
    assign unused_irq = timer_irq;
    assign irq_pend   = 1'b0;
`endif

    // Only direct-mode mtvec is supported, so the mode bits are dropped.
    logic unused_mtvec_mode;
    assign unused_mtvec_mode = ^csr_mtvec[1:0];

    assign irq_take = irq_pend & csr_mstatus[MSTATUS_MIE];

    trap_cause_enc #(
        .XLEN (XLEN)
    ) u_enc (
        .irq     (irq_take),
        .illegal (ex_illegal),
        .ecall   (ex_ecall),
        .mret    (ex_mret),
        .take    (ev_take),
        .is_mret (ev_is_mret),
        .cause   (ev_cause)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            trap_req    <= 1'b0;
            trap_cause  <= '0;
            trap_epc    <= '0;
            csr_wen     <= 1'b0;
            csr_waddr   <= '0;
            csr_wdata   <= '0;
            core_stall  <= 1'b0;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (ex_valid && ev_take) begin
                        core_stall <= 1'b1;
                        if (ev_is_mret) begin
                            state_q   <= MRET;
                            csr_wen   <= 1'b1;
                            csr_waddr <= XLEN'(CSR_MSTATUS);
                            csr_wdata <= mret_mstatus(csr_mstatus);
                            redir_pc  <= csr_mepc;
                        end else begin
                            state_q    <= TRAP;
                            trap_req   <= 1'b1;
                            trap_cause <= ev_cause;
                            trap_epc   <= ex_pc;
                            redir_pc   <= {csr_mtvec[XLEN-1:2], 2'b00};
                        end
                    end
                end
                TRAP: begin
                    trap_req    <= 1'b0;
                    redir_valid <= 1'b1;
                    state_q     <= REDIR;
                end
                MRET: begin
                    csr_wen     <= 1'b0;
                    csr_waddr   <= '0;
                    csr_wdata   <= '0;
                    redir_valid <= 1'b1;
                    state_q     <= REDIR;
                end
                REDIR: begin
                    if (redir_ready) begin
                        redir_valid <= 1'b0;
                        core_stall  <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
